mem_interface: RTL and testbench

// Memory access unit between the microcoded control FSM and the system bus. Accepts

---
 rtl/mem_interface.sv | 184 ++++++++++++++++++
 tb/tb_mem_interface.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - memory access unit between control FSM and system bus
//
// Runs one bus transaction per control request. It handles byte lanes,
// misalignment, and size/sign adjustment of load data. Bus errors and timeouts
// are reported as faults.
//
// Ports:
//   clk, rst_n                  core clock, asynchronous active-low reset
//   mem_read, mem_write         level requests from control, held until mem_complete
//   mem_fetch                   instruction fetch: forces word, unsigned
//   addr, f3, wdata             byte address, funct3 size code, LSB-aligned store data
//   mem_complete                one-cycle completion pulse
//   mem_rdata                   extended read data, held until next successful read
//   mem_fault, fault_cause      fault flag and cause (01 misaligned, 10 bus err, 11 timeout)
//   bus_req, bus_we, bus_addr   bus request, write flag, word-aligned address
//   bus_be, bus_wdata           byte enables, lane-replicated store data
//   bus_ack, bus_err, bus_rdata bus response
module mem_interface #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_fetch,
    input  logic [31:0] addr,
    input  logic [2:0]  f3,
    input  logic [31:0] wdata,
    output logic        mem_complete,
    output logic [31:0] mem_rdata,
    output logic        mem_fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state_q;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          fetch_q;
    logic [CW-1:0] cnt_q;

    logic          complete_q, fault_q, req_q, we_q;
    logic [1:0]    cause_q;
    logic [31:0]   rdata_q, addr_q, wdata_q;
    logic [3:0]    be_q;

    // Request decode: fetch and reserved codes behave as a word access.
    logic          is_b, is_h, misaligned_d;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;

    always_comb begin
        is_b = !mem_fetch && (f3[1:0] == 2'b00);
        is_h = !mem_fetch && (f3[1:0] == 2'b01);
        if (is_h)
            misaligned_d = addr[0];
        else
            misaligned_d = !is_b && (addr[1:0] != 2'b00);
        if (is_b) begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
        end else if (is_h) begin
            be_d    = 4'b0011 << addr[1:0];
            wdata_d = {2{wdata[15:0]}};
        end else begin
            be_d    = 4'b1111;
            wdata_d = wdata;
        end
    end

    // Load data: pick the addressed lane, then sign- or zero-extend.
    logic [15:0] lane;
    logic [31:0] rdata_ext_d;

    always_comb begin
        lane        = 16'(bus_rdata >> {off_q, 3'b000});
        rdata_ext_d = bus_rdata;
        if (!fetch_q) begin
            case (f3_q)
                3'b000:  rdata_ext_d = {{24{lane[7]}}, lane[7:0]};
                3'b001:  rdata_ext_d = {{16{lane[15]}}, lane};
                3'b100:  rdata_ext_d = {24'h0, lane[7:0]};
                3'b101:  rdata_ext_d = {16'h0, lane};
                default: rdata_ext_d = bus_rdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            off_q      <= '0;
            f3_q       <= '0;
            fetch_q    <= 1'b0;
            cnt_q      <= '0;
            complete_q <= 1'b0;
            fault_q    <= 1'b0;
            cause_q    <= 2'b00;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        off_q   <= addr[1:0];
                        f3_q    <= f3;
                        fetch_q <= mem_fetch;
                        cnt_q   <= '0;
                        if (misaligned_d) begin
                            // Fault without touching the bus.
                            state_q    <= DONE;
                            complete_q <= 1'b1;
                            fault_q    <= 1'b1;
                            cause_q    <= 2'b01;
                        end else begin
                            state_q <= BUS;
                            req_q   <= 1'b1;
                            we_q    <= mem_write;
                            addr_q  <= {addr[31:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                        end
                    end
                end
                BUS: begin
                    // An ack in the final timeout cycle still wins.
                    if (bus_ack) begin
                        state_q    <= DONE;
                        req_q      <= 1'b0;
                        complete_q <= 1'b1;
                        if (bus_err) begin
                            fault_q <= 1'b1;
                            cause_q <= 2'b10;
                        end else if (!we_q) begin
                            rdata_q <= rdata_ext_d;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                        state_q    <= DONE;
                        req_q      <= 1'b0;
                        complete_q <= 1'b1;
                        fault_q    <= 1'b1;
                        cause_q    <= 2'b11;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    complete_q <= 1'b0;
                    fault_q    <= 1'b0;
                    cause_q    <= 2'b00;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_complete = complete_q;
    assign mem_rdata    = rdata_q;
    assign mem_fault    = fault_q;
    assign fault_cause  = cause_q;
    assign bus_req      = req_q;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_be       = be_q;
    assign bus_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_interface.sv
// tb/tb_mem_interface.sv - directed self-checking bench for mem_interface
module tb_mem_interface;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_fetch;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic        mem_complete, mem_fault;
    logic [31:0] mem_rdata;
    logic [1:0]  fault_cause;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    int          r_done;
    logic        r_fault, r_req1, r_we1, r_req_done;
    logic [1:0]  r_cause;
    logic [3:0]  r_be1;
    logic [31:0] r_wd1, r_addr1;
    int          n_complete;

    mem_interface #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_fetch(mem_fetch),
        .addr(addr), .f3(f3), .wdata(wdata),
        .mem_complete(mem_complete), .mem_rdata(mem_rdata),
        .mem_fault(mem_fault), .fault_cause(fault_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Request issued in cycle 0; the bus acks in cycle ack_cyc (never if <= 0).
    task automatic run_access(input logic rd, input logic wr, input logic fe,
                              input logic [31:0] a, input logic [2:0] f,
                              input logic [31:0] wd, input int ack_cyc,
                              input logic err, input logic [31:0] rdat);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_fetch = fe;
        addr = a; f3 = f; wdata = wd;
        r_done = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus_ack = 1'b0; bus_err = 1'b0;
            if (c == 1) begin
                r_req1 = bus_req; r_we1 = bus_we; r_be1 = bus_be;
                r_wd1 = bus_wdata; r_addr1 = bus_addr;
            end
            if (mem_complete) begin
                r_done = c; r_fault = mem_fault; r_cause = fault_cause;
                r_req_done = bus_req;
                mem_read = 1'b0; mem_write = 1'b0; mem_fetch = 1'b0;
                break;
            end
            if (c == ack_cyc) begin
                bus_ack = 1'b1; bus_err = err; bus_rdata = rdat;
            end
        end
        if (r_done < 0) begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read = 0; mem_write = 0; mem_fetch = 0;
        addr = 0; f3 = 0; wdata = 0;
        bus_ack = 0; bus_err = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("rst_complete", 32'(mem_complete), 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'h0);
        check_eq("rst_cause", 32'(fault_cause), 32'd0);
        rst_n = 1'b1;

        // Fetch, ack in cycle 3.
        run_access(1, 0, 1, 32'h100, 3'b000, 0, 3, 0, 32'h00500093);
        check_eq("fetch_be", 32'(r_be1), 32'hF);
        check_eq("fetch_addr", r_addr1, 32'h100);
        check_eq("fetch_req", 32'(r_req1), 32'd1);
        check_eq("fetch_done_cyc", 32'(r_done), 32'd4);
        check_eq("fetch_fault", 32'(r_fault), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("fetch_rdata_held", mem_rdata, 32'h00500093);

        // LB / LBU at lane 3, minimum latency.
        run_access(1, 0, 0, 32'h203, 3'b000, 0, 1, 0, 32'h80FFFFFF);
        check_eq("lb_done_cyc", 32'(r_done), 32'd2);
        check_eq("lb_be", 32'(r_be1), 32'h8);
        check_eq("lb_rdata", mem_rdata, 32'hFFFFFF80);
        run_access(1, 0, 0, 32'h203, 3'b100, 0, 1, 0, 32'h80FFFFFF);
        check_eq("lbu_rdata", mem_rdata, 32'h00000080);

        // LH / LHU at upper half.
        run_access(1, 0, 0, 32'h402, 3'b001, 0, 2, 0, 32'h80011234);
        check_eq("lh_rdata", mem_rdata, 32'hFFFF8001);
        run_access(1, 0, 0, 32'h402, 3'b101, 0, 1, 0, 32'h80011234);
        check_eq("lhu_rdata", mem_rdata, 32'h00008001);

        // SH at 0x302 leaves mem_rdata alone.
        run_access(0, 1, 0, 32'h302, 3'b001, 32'h1234ABCD, 2, 0, 32'hDEADBEEF);
        check_eq("sh_we", 32'(r_we1), 32'd1);
        check_eq("sh_be", 32'(r_be1), 32'hC);
        check_eq("sh_wdata", r_wd1, 32'hABCDABCD);
        check_eq("sh_addr", r_addr1, 32'h300);
        check_eq("sh_rdata_kept", mem_rdata, 32'h00008001);

        // SB at lane 1.
        run_access(0, 1, 0, 32'h101, 3'b000, 32'hAAAA0155, 1, 0, 0);
        check_eq("sb_be", 32'(r_be1), 32'h2);
        check_eq("sb_wdata", r_wd1, 32'h55555555);

        // Misaligned LW: fault in cycle 1, no bus request.
        run_access(1, 0, 0, 32'h401, 3'b010, 0, 1, 0, 32'h11111111);
        check_eq("mis_done_cyc", 32'(r_done), 32'd1);
        check_eq("mis_req", 32'(r_req1), 32'd0);
        check_eq("mis_cause", 32'(r_cause), 32'd1);
        check_eq("mis_fault", 32'(r_fault), 32'd1);
        check_eq("mis_rdata_kept", mem_rdata, 32'h00008001);

        // Misaligned LH at odd address.
        run_access(1, 0, 0, 32'h403, 3'b001, 0, 1, 0, 0);
        check_eq("mis_h_cause", 32'(r_cause), 32'd1);

        // Reserved f3 behaves as a word.
        run_access(1, 0, 0, 32'h500, 3'b011, 0, 1, 0, 32'hCAFEF00D);
        check_eq("rsv_be", 32'(r_be1), 32'hF);
        check_eq("rsv_rdata", mem_rdata, 32'hCAFEF00D);

        // Bus error on ack.
        run_access(1, 0, 0, 32'h600, 3'b010, 0, 2, 1, 32'h12345678);
        check_eq("err_cause", 32'(r_cause), 32'd2);
        check_eq("err_fault", 32'(r_fault), 32'd1);
        check_eq("err_rdata_kept", mem_rdata, 32'hCAFEF00D);

        // Timeout after 4 BUS cycles.
        run_access(1, 0, 0, 32'h700, 3'b010, 0, 0, 0, 0);
        check_eq("to_done_cyc", 32'(r_done), 32'd5);
        check_eq("to_cause", 32'(r_cause), 32'd3);
        check_eq("to_req_low", 32'(r_req_done), 32'd0);

        // Ack in the last timeout cycle wins.
        run_access(1, 0, 0, 32'h700, 3'b010, 0, 4, 0, 32'h0BADCAFE);
        check_eq("to_ack_cause", 32'(r_cause), 32'd0);
        check_eq("to_ack_rdata", mem_rdata, 32'h0BADCAFE);

        // Reset pulsed mid-BUS.
        @(negedge clk);
        mem_read = 1; mem_fetch = 0; addr = 32'h800; f3 = 3'b010;
        repeat (2) @(negedge clk);
        check_eq("rstmid_req_before", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("rstmid_req_now", 32'(bus_req), 32'd0);
        mem_read = 0;
        @(negedge clk);
        rst_n = 1'b1;
        n_complete = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_complete) n_complete++;
        end
        check_eq("rstmid_no_complete", 32'(n_complete), 32'd0);
        check_eq("rstmid_rdata", mem_rdata, 32'h0);
        run_access(1, 0, 0, 32'h900, 3'b010, 0, 1, 0, 32'h13579BDF);
        check_eq("post_rst_done_cyc", 32'(r_done), 32'd2);
        check_eq("post_rst_rdata", mem_rdata, 32'h13579BDF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
